wb_dma_ch_arb: RTL and testbench

Channel request scheduler that sits in front of the DMA transfer engine.
- Samples per-channel peripheral handshake requests (dma_req_i) and selects one channel at a time by programmable priority, breaking ties round-robin.
- Presents the winner to the engine with a valid/ready grant and tracks it until the engine reports done or error.
- Returns the per-channel dma_ack_o pulse to the requesting peripheral.

---
 rtl/wb_dma_arb_pkg.sv | 13 +
 rtl/wb_dma_pri_sel.sv | 41 ++++
 rtl/wb_dma_ch_arb.sv | 91 +++++++++
 tb/tb_wb_dma_ch_arb.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_dma_arb_pkg.sv
// Shared types and helpers for the DMA channel request scheduler.
package wb_dma_arb_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, BUSY} arb_state_e;

    // Priority floor used as the starting point of the max search.
    localparam int unsigned PRI_RST = 0;

    function automatic int ch_w_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_dma_pri_sel.sv
// Combinational winner select: highest priority first, ties broken by
// round-robin distance from the last accepted channel.
module wb_dma_pri_sel
    import wb_dma_arb_pkg::*;
#(
    parameter  int ch_count = 8,
    parameter  int pri_w    = 3,
    localparam int ch_w     = ch_w_f(ch_count)
) (
    input  logic [ch_count-1:0]       eligible,
    input  logic [ch_count*pri_w-1:0] pri,
    input  logic [ch_w-1:0]           last,
    output logic                      found,
    output logic [ch_w-1:0]           idx
);

    logic [pri_w-1:0] max_pri;
    int               best_d;
    int               d;

    always_comb begin
        max_pri = pri_w'(PRI_RST);
        found   = |eligible;
        idx     = '0;
        best_d  = ch_count;
        d       = 0;
        for (int i = 0; i < ch_count; i++) begin
            if (eligible[i] && pri[i*pri_w +: pri_w] > max_pri)
                max_pri = pri[i*pri_w +: pri_w];
        end
        // Distance 0 is the channel just after last, so the scan wraps naturally.
        for (int i = 0; i < ch_count; i++) begin
            d = (i + 2*ch_count - int'(last) - 1) % ch_count;
            if (eligible[i] && pri[i*pri_w +: pri_w] == max_pri && d < best_d) begin
                best_d = d;
                idx    = ch_w'(i);
            end
        end
    end

endmodule

// File: rtl/wb_dma_ch_arb.sv
// DMA channel request scheduler: picks one requesting channel, offers it to
// the transfer engine, and returns the ack or error pulse when it finishes.
module wb_dma_ch_arb
    import wb_dma_arb_pkg::*;
#(
    parameter  int ch_count = 8,
    parameter  int pri_w    = 3,
    localparam int ch_w     = ch_w_f(ch_count)
) (
    input  logic                      clk,
    input  logic                      rst_i,
    input  logic [ch_count-1:0]       dma_req_i,
    input  logic [ch_count-1:0]       ch_en_i,
    input  logic [ch_count*pri_w-1:0] pri_i,
    output logic                      grant_valid_o,
    output logic [ch_w-1:0]           grant_ch_o,
    input  logic                      grant_ready_i,
    input  logic                      done_i,
    input  logic                      err_i,
    output logic [ch_count-1:0]       dma_ack_o,
    output logic                      err_o,
    output logic                      busy_o
);

    arb_state_e          state, state_nxt;
    logic [ch_count-1:0] holdoff;
    logic [ch_count-1:0] eligible;
    logic [ch_count-1:0] grant_oh;
    logic [ch_w-1:0]     last;
    logic                sel_found;
    logic [ch_w-1:0]     sel_idx;

    assign eligible      = dma_req_i & ch_en_i & ~holdoff;
    assign grant_oh      = ch_count'(1) << grant_ch_o;
    assign grant_valid_o = (state == GRANT);
    assign busy_o        = (state != IDLE);

    wb_dma_pri_sel #(.ch_count(ch_count), .pri_w(pri_w)) u_sel (
        .eligible (eligible),
        .pri      (pri_i),
        .last     (last),
        .found    (sel_found),
        .idx      (sel_idx)
    );

    always_ff @(posedge clk) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_found) state_nxt = GRANT;
            GRANT:   if (grant_ready_i) state_nxt = BUSY;
            BUSY:    if (done_i || err_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            grant_ch_o <= '0;
            last       <= ch_w'(ch_count - 1);
            holdoff    <= '0;
            dma_ack_o  <= '0;
            err_o      <= 1'b0;
        end else begin
            dma_ack_o <= '0;
            err_o     <= 1'b0;
            holdoff   <= '0;
            case (state)
                IDLE:  if (sel_found) grant_ch_o <= sel_idx;
                GRANT: if (grant_ready_i) last <= grant_ch_o;
                BUSY: begin
                    // Finished channel sits out the first IDLE cycle so its
                    // peripheral has time to drop the request after the ack.
                    if (err_i) begin
                        err_o   <= 1'b1;
                        holdoff <= grant_oh;
                    end else if (done_i) begin
                        dma_ack_o <= grant_oh;
                        holdoff   <= grant_oh;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_dma_ch_arb.sv
// Directed bench for the DMA channel scheduler with hand-computed expectations.
module tb_wb_dma_ch_arb;

    localparam int N  = 8;
    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [N-1:0]  dma_req_i;
    logic [N-1:0]  ch_en_i;
    logic [N*PW-1:0] pri_i;
    logic          grant_valid_o;
    logic [2:0]    grant_ch_o;
    logic          grant_ready_i;
    logic          done_i;
    logic          err_i;
    logic [N-1:0]  dma_ack_o;
    logic          err_o;
    logic          busy_o;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_dma_ch_arb #(.ch_count(N), .pri_w(PW)) dut (
        .clk           (clk),
        .rst_i         (rst_i),
        .dma_req_i     (dma_req_i),
        .ch_en_i       (ch_en_i),
        .pri_i         (pri_i),
        .grant_valid_o (grant_valid_o),
        .grant_ch_o    (grant_ch_o),
        .grant_ready_i (grant_ready_i),
        .done_i        (done_i),
        .err_i         (err_i),
        .dma_ack_o     (dma_ack_o),
        .err_o         (err_o),
        .busy_o        (busy_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic wait_grant(input string tag, input int exp_ch);
        int n = 0;
        while (grant_valid_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(grant_valid_o), 1);
        chk({tag, "_ch"}, 32'(grant_ch_o), exp_ch);
    endtask

    task automatic finish_xfer(input string tag, input int ch);
        logic [31:0] e;
        e = 32'd1 << ch;
        grant_ready_i = 1'b1;
        tick();
        grant_ready_i = 1'b0;
        chk({tag, "_busy"}, 32'(busy_o), 1);
        chk({tag, "_nogv"}, 32'(grant_valid_o), 0);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        chk({tag, "_ack"}, 32'(dma_ack_o), e);
    endtask

    initial begin
        rst_i = 1'b1; dma_req_i = '0; ch_en_i = '1; pri_i = '0;
        grant_ready_i = 1'b0; done_i = 1'b0; err_i = 1'b0;
        tick(); tick();
        rst_i = 1'b0;
        chk("rst_gv", 32'(grant_valid_o), 0);
        chk("rst_ch", 32'(grant_ch_o), 0);
        chk("rst_ack", 32'(dma_ack_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_busy", 32'(busy_o), 0);

        // 1: basic handshake with exact latencies
        dma_req_i = 8'h08;
        tick();
        chk("t1_gv", 32'(grant_valid_o), 1);
        chk("t1_ch", 32'(grant_ch_o), 3);
        tick();
        grant_ready_i = 1'b1;
        tick();
        grant_ready_i = 1'b0;
        chk("t1_busy", 32'(busy_o), 1);
        tick(); tick();
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        dma_req_i = '0;
        chk("t1_ack", 32'(dma_ack_o), 32'h08);
        chk("t1_idle", 32'(busy_o), 0);
        tick();
        chk("t1_ack_clr", 32'(dma_ack_o), 0);
        tick();

        // 2: higher priority wins, then the lower one
        pri_i = '0;
        pri_i[1*PW +: PW] = 3'd2;
        pri_i[6*PW +: PW] = 3'd5;
        dma_req_i = 8'h42;
        wait_grant("t2_a", 6);
        finish_xfer("t2_a", 6);
        dma_req_i = 8'h02;
        wait_grant("t2_b", 1);
        finish_xfer("t2_b", 1);
        dma_req_i = '0;
        pri_i = '0;
        tick();

        // 3: round-robin wrap, then holdoff on a lone requester
        do_reset();
        dma_req_i = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            wait_grant($sformatf("t3_rr%0d", k), k % N);
            finish_xfer($sformatf("t3_rr%0d", k), k % N);
        end
        dma_req_i = 8'h80;
        wait_grant("t3_h", 7);
        finish_xfer("t3_h", 7);
        tick();
        chk("t3_holdoff", 32'(grant_valid_o), 0);
        tick();
        chk("t3_regrant_gv", 32'(grant_valid_o), 1);
        chk("t3_regrant_ch", 32'(grant_ch_o), 7);
        dma_req_i = '0;
        finish_xfer("t3_r", 7);
        tick();

        // 4: err and done together -> err wins, no ack
        dma_req_i = 8'h14;
        wait_grant("t4", 2);
        grant_ready_i = 1'b1;
        tick();
        grant_ready_i = 1'b0;
        err_i = 1'b1; done_i = 1'b1;
        tick();
        err_i = 1'b0; done_i = 1'b0;
        chk("t4_err", 32'(err_o), 1);
        chk("t4_errch", 32'(grant_ch_o), 2);
        chk("t4_noack", 32'(dma_ack_o), 0);
        dma_req_i = 8'h10;
        tick();
        chk("t4_err_clr", 32'(err_o), 0);
        chk("t4_rearb_gv", 32'(grant_valid_o), 1);
        chk("t4_rearb_ch", 32'(grant_ch_o), 4);
        finish_xfer("t4_b", 4);
        dma_req_i = '0;
        tick();

        // 5: disabled channel never granted; stalled grant stays put
        ch_en_i = 8'hEF;
        dma_req_i = 8'h10;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("t5_dis%0d", k), 32'(grant_valid_o), 0);
        end
        ch_en_i = 8'hFF;
        tick();
        chk("t5_gv", 32'(grant_valid_o), 1);
        chk("t5_ch", 32'(grant_ch_o), 4);
        for (int k = 0; k < 10; k++) begin
            if (k == 5) begin
                dma_req_i = '0;
                ch_en_i = 8'h00;
            end
            tick();
            chk($sformatf("t5_stall_gv%0d", k), 32'(grant_valid_o), 1);
            chk($sformatf("t5_stall_ch%0d", k), 32'(grant_ch_o), 4);
        end
        ch_en_i = 8'hFF;
        finish_xfer("t5", 4);
        tick();

        // 6: reset while busy drops the transfer; pointer returns to 7
        dma_req_i = 8'h20;
        wait_grant("t6", 5);
        grant_ready_i = 1'b1;
        tick();
        grant_ready_i = 1'b0;
        tick();
        dma_req_i = 8'h21;
        rst_i = 1'b1; done_i = 1'b1;
        tick();
        rst_i = 1'b0; done_i = 1'b0;
        chk("t6_gv", 32'(grant_valid_o), 0);
        chk("t6_ch", 32'(grant_ch_o), 0);
        chk("t6_ack", 32'(dma_ack_o), 0);
        chk("t6_err", 32'(err_o), 0);
        chk("t6_busy", 32'(busy_o), 0);
        tick();
        chk("t6_post_gv", 32'(grant_valid_o), 1);
        chk("t6_post_ch", 32'(grant_ch_o), 0);
        chk("t6_post_ack", 32'(dma_ack_o), 0);
        dma_req_i = '0;
        finish_xfer("t6_b", 0);
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
